// File: rtl/decode_pkg.sv
// decode_pkg: opcode/funct encodings, control word and decode helpers
// shared by decode_pipe (load-use interlock under DECODE_PIPE_HAZARD_EN).
package decode_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JUMP  = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LDB   = 6'h20;
   localparam logic [5:0] OP_LDW   = 6'h23;
   localparam logic [5:0] OP_STB   = 6'h28;
   localparam logic [5:0] OP_STW   = 6'h2B;

   localparam logic [5:0] FN_MUL = 6'h18;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;

   typedef struct packed {
      logic regwrite;
      logic memtoreg;
      logic branch;
      logic memwrite;
      logic memread;
      logic byteword;
      logic alusrc;
      logic is_mult;
   } ctrl_t;

   typedef enum logic {
      RUN,
      INTERLOCK
   } state_t;

   // logical immediates are zero-extended
   function automatic logic is_zext(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
   endfunction

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LDW) || (op == OP_LDB);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_STW) || (op == OP_STB);
   endfunction

   function automatic logic rs2_used(input logic [5:0] op);
      return (op == OP_RTYPE) || is_store(op) ||
             (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl: combinational opcode/funct to 8-bit control word.
// Unknown opcodes decode to an all-zero (no side effect) word.
module decode_ctrl
   import decode_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      unique case (1'b1)
         (opcode == OP_RTYPE): begin
            ctrl.regwrite = 1'b1;
            ctrl.is_mult  = (funct == FN_MUL);
         end
         (is_zext(opcode) || opcode == OP_ADDI): begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
         end
         is_load(opcode): begin
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.memread  = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.byteword = (opcode == OP_LDB);
         end
         is_store(opcode): begin
            ctrl.memwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.byteword = (opcode == OP_STB);
         end
         (opcode == OP_BEQ || opcode == OP_BNE): begin
            ctrl.branch = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: one-deep decode stage with valid/ready handshakes and jump
// redirect; DECODE_PIPE_HAZARD_EN adds the load-use interlock FSM.
module decode_pipe
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int RADDR = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [31:0]      in_instr,
   input  logic             flush,
   output logic [RADDR-1:0] rf_addr1,
   output logic [RADDR-1:0] rf_addr2,
   input  logic [XLEN-1:0]  rf_data1,
   input  logic [XLEN-1:0]  rf_data2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_rs1_data,
   output logic [XLEN-1:0]  out_rs2_data,
   output logic [RADDR-1:0] out_rs1_addr,
   output logic [RADDR-1:0] out_rs2_addr,
   output logic [RADDR-1:0] out_dest,
   output logic [XLEN-1:0]  out_imm,
   output logic [5:0]       out_opcode,
   output logic [5:0]       out_funct,
   output logic [7:0]       out_ctrl,
   output logic             jump_valid,
   output logic [XLEN-1:0]  jump_addr
);

   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [RADDR-1:0] rs1;
   logic [RADDR-1:0] rs2;
   logic [RADDR-1:0] rd;
   logic [XLEN-1:0]  imm;
   ctrl_t            ctrl;
   logic             hazard;
   logic             accept;

   logic             valid_q, valid_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
   logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
   logic [RADDR-1:0] rs1_addr_q, rs1_addr_d;
   logic [RADDR-1:0] rs2_addr_q, rs2_addr_d;
   logic [RADDR-1:0] dest_q, dest_d;
   logic [XLEN-1:0]  imm_q, imm_d;
   logic [5:0]       opcode_q, opcode_d;
   logic [5:0]       funct_q, funct_d;
   ctrl_t            ctrl_q, ctrl_d;

   assign opcode = in_instr[31:26];
   assign funct  = in_instr[5:0];
   assign rs1    = RADDR'(in_instr[25:21]);
   assign rs2    = RADDR'(in_instr[20:16]);
   assign rd     = RADDR'(in_instr[15:11]);

   assign imm = is_zext(opcode)
              ? {{(XLEN-16){1'b0}}, in_instr[15:0]}
              : {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};

   decode_ctrl u_ctrl (
      .opcode (opcode),
      .funct  (funct),
      .ctrl   (ctrl)
   );

   assign rf_addr1 = rs1;
   assign rf_addr2 = rs2;

   assign in_ready = (!valid_q || out_ready) && !hazard;
   assign accept   = in_valid && in_ready && !flush;

   assign jump_addr  = {in_pc[XLEN-1:28], in_instr[25:0], 2'b00};
   assign jump_valid = accept && (opcode == OP_JUMP);

`ifdef DECODE_PIPE_HAZARD_EN
   state_t state_q, state_d;
   logic   hit1;
   logic   hit2;

   // r0 is hardwired to zero, so a load into it never blocks
   always_comb begin
      hit1   = (dest_q == rs1);
      hit2   = rs2_used(opcode) && (dest_q == rs2);
      hazard = valid_q && ctrl_q.memread &&
               (dest_q != '0) && (hit1 || hit2);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (in_valid && hazard && out_ready)
               state_d = INTERLOCK;
         end
         INTERLOCK: state_d = RUN;
      endcase
      if (flush)
         state_d = RUN;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= RUN;
      else
         state_q <= state_d;
   end
`else
   assign hazard = 1'b0;
`endif

   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      dest_d     = dest_q;
      imm_d      = imm_q;
      opcode_d   = opcode_q;
      funct_d    = funct_q;
      ctrl_d     = ctrl_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d    = 1'b1;
         pc_d       = in_pc;
         rs1_data_d = rf_data1;
         rs2_data_d = rf_data2;
         rs1_addr_d = rs1;
         rs2_addr_d = is_load(opcode) ? '0 : rs2;
         dest_d     = is_store(opcode) ? '0 :
                      is_load(opcode)  ? rs2 : rd;
         imm_d      = imm;
         opcode_d   = opcode;
         funct_d    = funct;
         ctrl_d     = ctrl;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         dest_q     <= '0;
         imm_q      <= '0;
         opcode_q   <= '0;
         funct_q    <= '0;
         ctrl_q     <= '0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         dest_q     <= dest_d;
         imm_q      <= imm_d;
         opcode_q   <= opcode_d;
         funct_q    <= funct_d;
         ctrl_q     <= ctrl_d;
      end
   end

   assign out_valid    = valid_q;
   assign out_pc       = pc_q;
   assign out_rs1_data = rs1_data_q;
   assign out_rs2_data = rs2_data_q;
   assign out_rs1_addr = rs1_addr_q;
   assign out_rs2_addr = rs2_addr_q;
   assign out_dest     = dest_q;
   assign out_imm      = imm_q;
   assign out_opcode   = opcode_q;
   assign out_funct    = funct_q;
   assign out_ctrl     = ctrl_q;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: scoreboard bench for decode_pipe; directed scenarios then
// random traffic against a transaction-level model (DECODE_PIPE_HAZARD_EN aware).
module tb_decode_pipe;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JUMP  = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LDB   = 6'h20;
   localparam logic [5:0] OP_LDW   = 6'h23;
   localparam logic [5:0] OP_STB   = 6'h28;
   localparam logic [5:0] OP_STW   = 6'h2B;
   localparam logic [5:0] FN_MUL   = 6'h18;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_OR    = 6'h25;

`ifdef DECODE_PIPE_HAZARD_EN
   localparam int EXP_BUBBLE = 1;
`else
   localparam int EXP_BUBBLE = 0;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
      logic [4:0]  rs1a;
      logic [4:0]  rs2a;
      logic [4:0]  dest;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [7:0]  ctrl;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        flush;
   logic [4:0]  rf_addr1;
   logic [4:0]  rf_addr2;
   logic [31:0] rf_data1;
   logic [31:0] rf_data2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_rs1_data;
   logic [31:0] out_rs2_data;
   logic [4:0]  out_rs1_addr;
   logic [4:0]  out_rs2_addr;
   logic [4:0]  out_dest;
   logic [31:0] out_imm;
   logic [5:0]  out_opcode;
   logic [5:0]  out_funct;
   logic [7:0]  out_ctrl;
   logic        jump_valid;
   logic [31:0] jump_addr;

   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   exp_t mon_a;
   exp_t mon_e;
   logic occ = 1'b0;
   logic last_acc = 1'b0;
   logic [31:0] held = '0;

   always #5 clk = ~clk;

   assign rf_data1 = {27'h5A5A5A5, rf_addr1};
   assign rf_data2 = {27'h3C3C3C3, rf_addr2};

   decode_pipe #(.XLEN(32), .RADDR(5)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
      .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
      .rf_data1(rf_data1), .rf_data2(rf_data2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rs1_data(out_rs1_data),
      .out_rs2_data(out_rs2_data), .out_rs1_addr(out_rs1_addr),
      .out_rs2_addr(out_rs2_addr), .out_dest(out_dest),
      .out_imm(out_imm), .out_opcode(out_opcode),
      .out_funct(out_funct), .out_ctrl(out_ctrl),
      .jump_valid(jump_valid), .jump_addr(jump_addr)
   );

   function automatic exp_t ref_dec(input logic [31:0] pc,
                                    input logic [31:0] ins);
      exp_t e;
      logic [5:0] op;
      logic [5:0] fn;
      logic ld, st, zx, ia;
      op = ins[31:26];
      fn = ins[5:0];
      ld = (op == OP_LDW) || (op == OP_LDB);
      st = (op == OP_STW) || (op == OP_STB);
      zx = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
      ia = zx || (op == OP_ADDI);
      e.pc   = pc;
      e.rs1d = {27'h5A5A5A5, ins[25:21]};
      e.rs2d = {27'h3C3C3C3, ins[20:16]};
      e.imm  = zx ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
      e.rs1a = ins[25:21];
      e.rs2a = ld ? 5'd0 : ins[20:16];
      e.dest = st ? 5'd0 : (ld ? ins[20:16] : ins[15:11]);
      e.op   = op;
      e.fn   = fn;
      e.ctrl = {(op == OP_RTYPE) || ia || ld, ld,
                (op == OP_BEQ) || (op == OP_BNE), st, ld,
                (op == OP_LDB) || (op == OP_STB), ia || ld || st,
                (op == OP_RTYPE) && (fn == FN_MUL)};
      return e;
   endfunction

   function automatic logic hazard_model();
      logic h;
      logic [5:0] op;
      logic [4:0] d;
      h  = 1'b0;
      op = in_instr[31:26];
      d  = held[20:16];
`ifdef DECODE_PIPE_HAZARD_EN
      if (occ && (held[31:26] == OP_LDW || held[31:26] == OP_LDB) &&
          d != 5'd0 &&
          (d == in_instr[25:21] ||
           ((op == OP_RTYPE || op == OP_STW || op == OP_STB ||
             op == OP_BEQ || op == OP_BNE) && d == in_instr[20:16])))
         h = 1'b1;
`endif
      return h;
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [5:0] ops [14];
      logic [5:0] fns [4];
      logic [5:0] op;
      logic [4:0] rs, rt, rd;
      ops = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_ADDI, OP_ORI, OP_ANDI,
              OP_XORI, OP_LDW, OP_LDB, OP_STW, OP_STB, OP_BEQ,
              OP_JUMP, 6'h3F};
      fns = '{FN_ADD, FN_SUB, FN_MUL, FN_OR};
      op = ops[$urandom_range(0, 13)];
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      if (op == OP_RTYPE)
         return {op, rs, rt, rd, 5'd0, fns[$urandom_range(0, 3)]};
      else if (op == OP_JUMP)
         return {op, 26'($urandom)};
      return {op, rs, rt, 16'($urandom)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one clock of the transaction model: checks, then edge, then +1
   task automatic step();
      logic er;
      logic ejv;
      @(negedge clk);
      er  = (!occ || out_ready) && !hazard_model();
      ejv = in_valid && er && !flush && (in_instr[31:26] == OP_JUMP);
      chk("out_valid", 64'(out_valid), 64'(occ));
      chk("in_ready", 64'(in_ready), 64'(er));
      chk("rf_addr1", 64'(rf_addr1), 64'(in_instr[25:21]));
      chk("rf_addr2", 64'(rf_addr2), 64'(in_instr[20:16]));
      chk("jump_valid", 64'(jump_valid), 64'(ejv));
      chk("jump_addr", 64'(jump_addr),
          64'({in_pc[31:28], in_instr[25:0], 2'b00}));
      last_acc = in_valid && er && !flush;
      if (flush) begin
         occ = 1'b0;
      end else if (last_acc) begin
         occ  = 1'b1;
         held = in_instr;
         sbq.push_back(ref_dec(in_pc, in_instr));
      end else if (out_ready) begin
         occ = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] ins,
                       output int waits);
      logic done;
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = ins;
      waits    = 0;
      done     = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         step();
         if (last_acc) done = 1'b1;
         else waits++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_timeout: pc %0h not accepted after 20 cycles", pc);
      end
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         mon_a = {out_pc, out_rs1_data, out_rs2_data, out_imm,
                  out_rs1_addr, out_rs2_addr, out_dest,
                  out_opcode, out_funct, out_ctrl};
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL monitor: got %h expected nothing", mon_a);
         end else begin
            mon_e = sbq.pop_front();
            if (mon_a !== mon_e) begin
               errors++;
               $display("FAIL monitor: got %h expected %h", mon_a, mon_e);
            end
         end
      end
   end

   initial begin
      int w;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_instr  = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      #3;
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_ctrl", 64'(out_ctrl), 64'd0);
      chk("reset_pc", 64'(out_pc), 64'd0);
      chk("reset_imm", 64'(out_imm), 64'd0);
      #9 reset = 1'b1;
      @(posedge clk);
      #1;

      // ADD r3,r1,r2 at pc 0x100
      send(32'h100, {OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, FN_ADD}, w);
      chk("add_valid", 64'(out_valid), 64'd1);
      chk("add_dest", 64'(out_dest), 64'd3);
      chk("add_pc", 64'(out_pc), 64'h100);
      chk("add_regwrite", 64'(out_ctrl[7]), 64'd1);
      step();

      // load-use: LDW r5 then ADD r6,r5,r1
      send(32'h200, {OP_LDW, 5'd2, 5'd5, 16'h0010}, w);
      send(32'h204, {OP_RTYPE, 5'd5, 5'd1, 5'd6, 5'd0, FN_ADD}, w);
      chk("load_use_bubble", 64'(w), 64'(EXP_BUBBLE));
      step();

      // 3-cycle downstream stall, next instruction waits
      out_ready = 1'b0;
      send(32'h300, {OP_RTYPE, 5'd4, 5'd7, 5'd2, 5'd0, FN_MUL}, w);
      in_valid = 1'b1;
      in_pc    = 32'h304;
      in_instr = {OP_ADDI, 5'd1, 5'd2, 16'h0005};
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", 64'(out_pc), 64'h300);
         chk("stall_funct", 64'(out_funct), 64'(FN_MUL));
      end
      out_ready = 1'b1;
      step();
      chk("stall_next_pc", 64'(out_pc), 64'h304);
      in_valid = 1'b0;
      step();

      // flush with a valid jump on the input
      in_valid = 1'b1;
      in_pc    = 32'h400;
      in_instr = {OP_JUMP, 26'h0000040};
      flush    = 1'b1;
      #2;
      chk("flush_jump_valid", 64'(jump_valid), 64'd0);
      step();
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      flush    = 1'b0;
      in_valid = 1'b0;

      // jump redirect
      in_valid = 1'b1;
      in_pc    = 32'h3000_0010;
      in_instr = {OP_JUMP, 26'h0000040};
      #2;
      chk("jump_valid", 64'(jump_valid), 64'd1);
      chk("jump_addr", 64'(jump_addr), 64'h3000_0100);
      send(32'h3000_0010, {OP_JUMP, 26'h0000040}, w);
      step();

      // immediate extension
      send(32'h500, {OP_ADDI, 5'd1, 5'd2, 16'h8000}, w);
      chk("addi_imm", 64'(out_imm), 64'hFFFF_8000);
      send(32'h504, {OP_ORI, 5'd1, 5'd2, 16'h8000}, w);
      chk("ori_imm", 64'(out_imm), 64'h0000_8000);
      step();

      // reset while stalled discards the held instruction
      out_ready = 1'b0;
      send(32'h600, {OP_RTYPE, 5'd1, 5'd2, 5'd9, 5'd0, FN_SUB}, w);
      step();
      #2 reset = 1'b0;
      #1;
      chk("rst_async_valid", 64'(out_valid), 64'd0);
      chk("rst_async_ctrl", 64'(out_ctrl), 64'd0);
      chk("rst_async_pc", 64'(out_pc), 64'd0);
      sbq.delete();
      occ      = 1'b0;
      in_valid = 1'b1;
      in_instr = {OP_ADDI, 5'd3, 5'd4, 16'h0001};
      @(posedge clk);
      #1;
      chk("rst_no_accept", 64'(out_valid), 64'd0);
      @(negedge clk);
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // random traffic
      for (int c = 0; c < 800; c++) begin
         if (!in_valid || last_acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = rnd_instr();
            in_pc    = $urandom & 32'hFFFF_FFFC;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = out_ready && ($urandom_range(0, 19) == 0);
         step();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("drain_empty", 64'(sbq.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
